lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit on the CPU side of the byte-addressed instruction/data RAM.
- Accepts one CPU memory request at a time: byte, halfword or word, load or store, signed or unsigned.
- Drives the RAM's single 16-bit write port and its combinational 32-bit little-endian read port.
- Word stores are sequenced as two halfword writes. Byte stores use read-modify-write, because the RAM always writes two bytes.

Parameters:
- ADDR_W, 16, RAM byte-address width.
- MEM_BYTES, 32768, implemented RAM size in bytes; used only by the optional range check.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  CPU request present.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  in  1  sign-extend byte/half loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse, loads and stores.
- resp_rdata  out  32  load result, valid with resp_valid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wd  out  16  RAM write data; low byte goes to addr, high byte to addr+1.
- ram_data  in  32  RAM read data, combinational from ram_addr: {m[a+3],m[a+2],m[a+1],m[a]}.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, ram_we=0, ram_addr=0, ram_wd=0. All internal request registers are 0.
- Accept happens on a clock edge with req_valid && req_ready. At that edge addr, size, signed, we and wdata are registered. Inputs are ignored in all other states.
- FSM states: IDLE, LOAD, RMW, WR_LO, WR_HI, DONE.
- IDLE transitions on accept:
  - load -> LOAD
  - byte store -> RMW
  - half or word store -> WR_LO
- LOAD:
  - ram_addr = addr.
  - At the edge, resp_rdata <= aligned result, then -> DONE.
  - Byte result is ram_data[7:0]; half result is ram_data[15:0]; word result is ram_data.
  - Byte/half results are zero- or sign-extended per signed.
- RMW:
  - ram_addr = addr; latch hi_keep <= ram_data[15:8].
  - -> WR_LO.
- WR_LO:
  - ram_we=1, ram_addr = addr.
  - ram_wd = {hi_keep, wdata[7:0]} for byte, wdata[15:0] otherwise.
  - Word -> WR_HI; else -> DONE.
- WR_HI:
  - ram_we=1, ram_addr = addr+2, truncated to ADDR_W so it wraps (0xFFFF+2 = 0x0001).
  - ram_wd = wdata[31:16].
  - -> DONE.
- DONE: resp_valid=1 for exactly one cycle, then -> IDLE. req_ready is 0 in DONE.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles
  - half store: 2 cycles
  - word store: 3 cycles
  - byte store: 3 cycles
- ram_we, ram_addr and ram_wd are decoded combinationally from state and registers. ram_we is never high outside WR_LO/WR_HI.
- Misaligned addresses are legal without the optional feature. The RAM is byte-addressed, so word reads at any offset are served as-is.
- Reset asserted mid-operation: returns to IDLE immediately and ram_we drops asynchronously. A word store interrupted after WR_LO leaves only the low half written. This is accepted, not repaired.
- resp_rdata holds its value until the next load completes. Stores do not modify it.

Optional Feature:
- Macro: LSU_ERR_EN.
- Defined:
  - Adds output port resp_err (1 bit, reset 0, valid with resp_valid).
  - An error is: half with addr[0]=1; word with addr[1:0]!=0; or addr+bytes-1 >= MEM_BYTES.
  - An erroring request goes IDLE -> DONE directly: no RAM write, resp_rdata <= 0, resp_err=1.
- Undefined: no port, no check, misaligned accesses proceed as above.

Decomposition:
- Package lsu_pkg holds:
  - size_e (SZ_B, SZ_H, SZ_W)
  - state_e (the six states)
  - constants for size encodings.
- One sub-module, lsu_load_align: combinational; inputs ram_data, size, signed; output 32-bit result. It is unit-testable alone.

Test Plan:
- Preload m[0x10..0x13]=78 56 34 12; word load addr 0x0010 -> resp_valid 2 cycles after accept, resp_rdata=0x12345678.
- Preload m[0x20]=0x80; byte load signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Word store 0xDEADBEEF @0x0040:
  - WR_LO writes 0xBEEF @0x40, then WR_HI writes 0xDEAD @0x42.
  - resp_valid 3 cycles after accept.
  - Word readback = 0xDEADBEEF.
- Preload m[0x51]=0xAA; byte store 0x5C @0x0050 -> m[0x50]=0x5C, m[0x51]=0xAA unchanged.
- Assert rst during WR_HI of a word store -> ram_we=0 in the same cycle, state IDLE, req_ready=1, resp_valid never pulses.
- With LSU_ERR_EN: half store @0x0031 -> no ram_we pulse, resp_valid+resp_err 1 cycle after accept, memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   size_e  : access size (byte / half / word), encoded as on req_size
//   state_e : LSU control FSM states
//   decode_size() folds the reserved size code 2'b11 onto word.
// Optional feature macro used elsewhere in the slice: LSU_ERR_EN.
package lsu_pkg;

  localparam logic [1:0] SIZE_ENC_B = 2'b00;
  localparam logic [1:0] SIZE_ENC_H = 2'b01;
  localparam logic [1:0] SIZE_ENC_W = 2'b10;

  typedef enum logic [1:0] {
    SZ_B = SIZE_ENC_B,
    SZ_H = SIZE_ENC_H,
    SZ_W = SIZE_ENC_W
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RMW   = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic size_e decode_size(input logic [1:0] enc);
    case (enc)
      SIZE_ENC_B: decode_size = SZ_B;
      SIZE_ENC_H: decode_size = SZ_H;
      default:    decode_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: CPU-side request/response bundle of the load/store unit.
//   req_*  : one request, accepted on req_valid && req_ready
//   resp_* : one-cycle completion pulse with load data
//   resp_err is present only when LSU_ERR_EN is defined.
// Modports: master = CPU side, slave = LSU side.
interface lsu_if #(parameter int ADDR_W = 16);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
`ifdef LSU_ERR_EN
  logic              resp_err;
`endif

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
`ifdef LSU_ERR_EN
    , input resp_err
`endif
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
`ifdef LSU_ERR_EN
    , output resp_err
`endif
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load result formatter.
//   ram_data : little-endian word read at the request address
//   size     : access size
//   sign_ext : sign-extend byte/half results when set
//   result   : right-aligned, zero- or sign-extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] ram_data,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  assign byte_s  = ram_data[7:0];
  assign half_s  = ram_data[15:0];
  assign byte_sx = byte_s;
  assign half_sx = half_s;

  always_comb begin
    result = ram_data;
    case (size)
      SZ_B: result = sign_ext ? byte_sx : {24'd0, ram_data[7:0]};
      SZ_H: result = sign_ext ? half_sx : {16'd0, ram_data[15:0]};
      default: result = ram_data;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the CPU and the byte-addressed RAM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lsu_if.slave, CPU request/response
//   ram_we, ram_addr, ram_wd : RAM 16-bit write port (low byte -> addr)
//   ram_data : RAM combinational 32-bit little-endian read at ram_addr
// Word stores go out as two halfword writes (addr, addr+2). Byte stores
// read the neighbouring byte first because the RAM always writes two bytes.
// Optional: `define LSU_ERR_EN adds bus.resp_err and rejects misaligned or
// out-of-range accesses without touching the RAM.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_BYTES = 32768
) (
  input  logic              clk,
  input  logic              rst,
  lsu_if.slave              bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wd,
  input  logic [31:0]       ram_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        hi_keep_q, hi_keep_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_result;
  logic              accept;
  logic              req_err;
  size_e             req_size_dec;

  assign accept       = bus.req_valid && (state_q == IDLE);
  assign req_size_dec = decode_size(bus.req_size);

`ifdef LSU_ERR_EN
  logic err_q, err_d;

  function automatic logic access_err(input size_e sz, input logic [ADDR_W-1:0] a);
    logic [31:0] last;
    logic        misal;
    case (sz)
      SZ_B:    begin last = 32'(a);         misal = 1'b0;          end
      SZ_H:    begin last = 32'(a) + 32'd1; misal = a[0];          end
      default: begin last = 32'(a) + 32'd3; misal = (a[1:0] != 2'b00); end
    endcase
    access_err = misal || (last >= 32'(MEM_BYTES));
  endfunction

  assign req_err      = access_err(req_size_dec, bus.req_addr);
  assign bus.resp_err = (state_q == DONE) && err_q;
`else
  assign req_err = 1'b0;
`endif

  lsu_load_align u_align (
    .ram_data (ram_data),
    .size     (size_q),
    .sign_ext (sgn_q),
    .result   (load_result)
  );

  // State and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= SZ_B;
      sgn_q     <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      hi_keep_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      hi_keep_q <= hi_keep_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef LSU_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = DONE;
          else if (!bus.req_we)        state_d = LOAD;
          else if (req_size_dec == SZ_B) state_d = RMW;
          else                         state_d = WR_LO;
        end
      end
      LOAD:    state_d = DONE;
      RMW:     state_d = WR_LO;
      WR_LO:   state_d = (size_q == SZ_W) ? WR_HI : DONE;
      WR_HI:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath register updates
  always_comb begin
    addr_d    = addr_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hi_keep_d = hi_keep_q;
    rdata_d   = rdata_q;
`ifdef LSU_ERR_EN
    err_d     = err_q;
`endif
    if (accept) begin
      addr_d  = bus.req_addr;
      size_d  = req_size_dec;
      sgn_d   = bus.req_signed;
      we_d    = bus.req_we;
      wdata_d = bus.req_wdata;
      // A rejected access completes immediately with zero data.
      if (req_err) rdata_d = '0;
`ifdef LSU_ERR_EN
      err_d   = req_err;
`endif
    end
    if (state_q == LOAD) rdata_d = load_result;
    // Keep the byte above the target so the two-byte write leaves it intact.
    if (state_q == RMW) hi_keep_d = ram_data[15:8];
  end

  // Outputs
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wd   = '0;
    case (state_q)
      LOAD, RMW: ram_addr = addr_q;
      WR_LO: begin
        ram_we   = we_q;
        ram_addr = addr_q;
        ram_wd   = (size_q == SZ_B) ? {hi_keep_q, wdata_q[7:0]} : wdata_q[15:0];
      end
      WR_HI: begin
        ram_we   = we_q;
        ram_addr = addr_q + ADDR_W'(2);
        ram_wd   = wdata_q[31:16];
      end
      default: ;
    endcase
  end

  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a behavioural byte-addressed RAM.
// Build with +define+LSU_ERR_EN to exercise the error-response path.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wd;
  logic [31:0] ram_data;

  logic [7:0]  mem [0:65535];
  logic [15:0] wlog_addr [$];
  logic [15:0] wlog_data [$];

  int n_chk  = 0;
  int n_fail = 0;

  lsu_if #(.ADDR_W(16)) bus ();

  lsu #(.ADDR_W(16), .MEM_BYTES(32768)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wd   (ram_wd),
    .ram_data (ram_data)
  );

  always #5 clk = ~clk;

  assign ram_data = {mem[16'(ram_addr + 16'd3)], mem[16'(ram_addr + 16'd2)],
                     mem[16'(ram_addr + 16'd1)], mem[ram_addr]};

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]               <= ram_wd[7:0];
      mem[16'(ram_addr + 16'd1)]  <= ram_wd[15:8];
      wlog_addr.push_back(ram_addr);
      wlog_data.push_back(ram_wd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its completion pulse.
  // lat = number of clock edges from the accept edge to the edge that sees resp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hFFFF_FFFF;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    rdata = bus.resp_rdata;
`ifdef LSU_ERR_EN
    err = bus.resp_err;
`else
    err = 1'b0;
`endif
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          pulses;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    mem[16'h10] <= 8'h78; mem[16'h11] <= 8'h56; mem[16'h12] <= 8'h34; mem[16'h13] <= 8'h12;
    mem[16'h14] <= 8'h9A;
    mem[16'h20] <= 8'h80;
    mem[16'h30] <= 8'h34; mem[16'h31] <= 8'h92;
    mem[16'h51] <= 8'hAA;
    mem[16'h62] <= 8'hA5; mem[16'h63] <= 8'h5A;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_ram_we",     {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr",   {16'd0, ram_addr}, 32'd0);
    check("rst_ram_wd",     {16'd0, ram_wd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, lat, rd, er);
    check("wload_lat",  lat, 2);
    check("wload_data", rd, 32'h1234_5678);

    do_req(1'b0, 2'b00, 1'b1, 16'h0020, 32'h0, lat, rd, er);
    check("bload_s_lat",  lat, 2);
    check("bload_s_data", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b0, 16'h0020, 32'h0, lat, rd, er);
    check("bload_u_data", rd, 32'h0000_0080);

    do_req(1'b0, 2'b01, 1'b1, 16'h0030, 32'h0, lat, rd, er);
    check("hload_s_data", rd, 32'hFFFF_9234);
    do_req(1'b0, 2'b01, 1'b0, 16'h0030, 32'h0, lat, rd, er);
    check("hload_u_data", rd, 32'h0000_9234);

    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b1, 2'b10, 1'b0, 16'h0040, 32'hDEAD_BEEF, lat, rd, er);
    check("wstore_lat",    lat, 3);
    check("wstore_rdata_hold", rd, 32'h0000_9234);
    check("wstore_nwr",    wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      check("wstore_lo_addr", {16'd0, wlog_addr[0]}, 32'h40);
      check("wstore_lo_data", {16'd0, wlog_data[0]}, 32'hBEEF);
      check("wstore_hi_addr", {16'd0, wlog_addr[1]}, 32'h42);
      check("wstore_hi_data", {16'd0, wlog_data[1]}, 32'hDEAD);
    end
    do_req(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, lat, rd, er);
    check("wstore_readback", rd, 32'hDEAD_BEEF);

    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b1, 2'b00, 1'b0, 16'h0050, 32'h0000_005C, lat, rd, er);
    check("bstore_lat",  lat, 3);
    check("bstore_m50",  {24'd0, mem[16'h50]}, 32'h5C);
    check("bstore_m51",  {24'd0, mem[16'h51]}, 32'hAA);
    check("bstore_nwr",  wlog_addr.size(), 1);
    if (wlog_addr.size() == 1)
      check("bstore_wd", {16'd0, wlog_data[0]}, 32'hAA5C);

    do_req(1'b1, 2'b01, 1'b0, 16'h0070, 32'h0000_1234, lat, rd, er);
    check("hstore_lat", lat, 2);
    check("hstore_mem", {16'd0, mem[16'h71], mem[16'h70]}, 32'h1234);

`ifndef LSU_ERR_EN
    do_req(1'b0, 2'b10, 1'b0, 16'h0011, 32'h0, lat, rd, er);
    check("misal_wload", rd, 32'h9A12_3456);

    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b1, 2'b11, 1'b0, 16'hFFFF, 32'h0102_0304, lat, rd, er);
    check("wrap_lat", lat, 3);
    check("wrap_nwr", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2)
      check("wrap_hi_addr", {16'd0, wlog_addr[1]}, 32'h0001);
    check("wrap_m0000", {24'd0, mem[16'h0000]}, 32'h03);
`else
    wlog_addr.delete(); wlog_data.delete();
    do_req(1'b1, 2'b01, 1'b0, 16'h0031, 32'h0000_BBCC, lat, rd, er);
    check("err_h_lat",   lat, 1);
    check("err_h_err",   {31'd0, er}, 32'd1);
    check("err_h_rdata", rd, 32'd0);
    check("err_h_nwr",   wlog_addr.size(), 0);
    check("err_h_mem",   {16'd0, mem[16'h32], mem[16'h31]}, 32'h0092);
    do_req(1'b0, 2'b10, 1'b0, 16'h0011, 32'h0, lat, rd, er);
    check("err_w_err",   {31'd0, er}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, lat, rd, er);
    check("ok_w_err",    {31'd0, er}, 32'd0);
    check("ok_w_data",   rd, 32'h1234_5678);
    do_req(1'b0, 2'b00, 1'b0, 16'h8000, 32'h0, lat, rd, er);
    check("err_range",   {31'd0, er}, 32'd1);
`endif

    // Reset during WR_HI of a word store.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 16'h0060;
    bus.req_wdata = 32'h1122_3344;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_we_before",   {31'd0, ram_we}, 32'd1);
    check("rst_mid_addr_before", {16'd0, ram_addr}, 32'h62);
    rst = 1'b1;
    #1;
    check("rst_mid_we",     {31'd0, ram_we}, 32'd0);
    check("rst_mid_ready",  {31'd0, bus.req_ready}, 32'd1);
    check("rst_mid_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid) pulses++;
    end
    check("rst_mid_pulses", pulses, 0);
    check("rst_mid_lo",     {16'd0, mem[16'h61], mem[16'h60]}, 32'h3344);
    check("rst_mid_hi",     {16'd0, mem[16'h63], mem[16'h62]}, 32'h5AA5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
